// File: rtl/ec11_encoder_if.sv
// ec11_encoder_if: EC11 rotary encoder front-end.
// Synchronises and debounces the raw A, B and push-switch pins. Decodes the
// quadrature pair into a WIDTH-bit detent position and turns a debounced
// press into a one-cycle load strobe for the downstream loadable counter.
//
// Optional build macro: EC11_SATURATE_EN
//   When defined, position saturates at 0 and 2^WIDTH-1 instead of wrapping.
//   A blocked step clears the sub-step accumulator, updates dir and emits no
//   step pulse.
module ec11_encoder_if #(
  parameter int WIDTH            = 8,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_sw,
  output logic [WIDTH-1:0] position,
  output logic             load,
  output logic             step,
  output logic             dir,
  output logic             err
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; the extra bit of
  // headroom keeps the compare free of any wrap for every legal setting.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Accumulator spans -STEPS_PER_DETENT .. +STEPS_PER_DETENT, signed.
  localparam int ACC_W = $clog2(STEPS_PER_DETENT + 1) + 1;
  localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;

  localparam logic [WIDTH-1:0] POS_MAX = '1;
  localparam logic [WIDTH-1:0] POS_MIN = '0;

`ifdef EC11_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // Channel index into the per-input vectors: 0 = A, 1 = B, 2 = switch.
  localparam int IDX_A  = 0;
  localparam int IDX_B  = 1;
  localparam int IDX_SW = 2;

  logic [2:0]             w_raw;
  logic [2:0]             r_sync1;
  logic [2:0]             r_sync2;
  logic [2:0]             r_filt;
  logic [CNT_W-1:0]       r_cnt [3];
  logic [2:0]             w_commit;

  logic [1:0]             r_ab_prev;
  logic [1:0]             w_ab_cur;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_delta;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic                   w_illegal;
  logic                   w_sw_press;

  // Quadrature step value for one filtered {A,B} transition.
  // CW order is 11 -> 01 -> 00 -> 10 -> 11; the reverse order counts down.
  // No change and double-bit changes contribute nothing here.
  function automatic logic signed [ACC_W-1:0] quad_delta(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    logic signed [ACC_W-1:0] d;
    d = '0;
    case ({prev, cur})
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: d = ACC_W'(1);
      4'b01_11, 4'b00_01, 4'b10_00, 4'b11_10: d = '1;
      default:                                d = '0;
    endcase
    return d;
  endfunction

  // Both channels flipping in one cycle cannot come from a real rotation.
  function automatic logic quad_illegal(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    return (prev ^ cur) == 2'b11;
  endfunction

  // True when a step in the given direction must be blocked by saturation.
  function automatic logic pos_at_limit(
    input logic [WIDTH-1:0] pos,
    input logic             up
  );
    logic hit;
    hit = up ? (pos == POS_MAX) : (pos == POS_MIN);
    return SATURATE && hit;
  endfunction

  assign w_raw    = {enc_sw, enc_b, enc_a};
  assign w_ab_cur = {r_filt[IDX_A], r_filt[IDX_B]};

  // Two-flop synchroniser per raw pin; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A filtered input flips once its synchronised value has differed for the
  // full debounce window.
  always_comb begin
    w_commit = '0;
    for (int i = 0; i < 3; i++) begin
      w_commit[i] = (r_sync2[i] != r_filt[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  // Independent debounce counter and filtered level for each input.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        r_cnt[i]  <= '0;
        r_filt[i] <= 1'b1;
      end else if (r_sync2[i] == r_filt[i]) begin
        r_cnt[i]  <= '0;
      end else if (w_commit[i]) begin
        r_filt[i] <= r_sync2[i];
        r_cnt[i]  <= '0;
      end else begin
        r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Decode terms for the current filtered pair against last cycle's pair.
  always_comb begin
    w_delta    = quad_delta(r_ab_prev, w_ab_cur);
    w_illegal  = quad_illegal(r_ab_prev, w_ab_cur);
    w_acc_sum  = r_acc + w_delta;
    // Switch is active-low: a commit while filtered is still high is a press.
    w_sw_press = w_commit[IDX_SW] & r_filt[IDX_SW];
  end

  // Sub-step accumulation, position update and the registered pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ab_prev <= 2'b11;
      r_acc     <= '0;
      position  <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      load      <= 1'b0;
    end else begin
      r_ab_prev <= w_ab_cur;
      step      <= 1'b0;
      err       <= 1'b0;
      load      <= w_sw_press;
      if (w_illegal) begin
        err <= 1'b1;
      end else if (w_acc_sum == ACC_POS) begin
        r_acc <= '0;
        dir   <= 1'b1;
        if (!pos_at_limit(position, 1'b1)) begin
          position <= position + WIDTH'(1);
          step     <= 1'b1;
        end
      end else if (w_acc_sum == ACC_NEG) begin
        r_acc <= '0;
        dir   <= 1'b0;
        if (!pos_at_limit(position, 1'b0)) begin
          position <= position - WIDTH'(1);
          step     <= 1'b1;
        end
      end else begin
        r_acc <= w_acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_ec11_encoder_if.sv
// Testbench for ec11_encoder_if with DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4,
// WIDTH=8. Expected output events are queued as stimulus is driven and
// compared by a monitor whenever step, load or err pulses.
module tb_ec11_encoder_if;

  localparam int WIDTH = 8;
  localparam int DB    = 4;
  localparam int SPD   = 4;
  // Raw edge to filtered change is 2 + DB; registered outputs add one more
  // cycle for decode, while load is produced on the filtering edge itself.
  localparam int LAT_FILT = 2 + DB;
  localparam int LAT_STEP = 3 + DB;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enc_a = 1'b1;
  logic             enc_b = 1'b1;
  logic             enc_sw = 1'b1;
  logic [WIDTH-1:0] position;
  logic             load;
  logic             step;
  logic             dir;
  logic             err;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int               cyc;
    logic             stp;
    logic             ld;
    logic             er;
    logic             dr;
    logic [WIDTH-1:0] pos;
  } ev_t;

  ev_t              exp_q[$];
  logic [WIDTH-1:0] exp_pos = '0;
  logic             exp_dir = 1'b0;

  ec11_encoder_if #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DB),
    .STEPS_PER_DETENT(SPD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .enc_sw(enc_sw),
    .position(position),
    .load(load),
    .step(step),
    .dir(dir),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every output pulse must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (step === 1'b1 || load === 1'b1 || err === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d step=%b load=%b err=%b pos=%0h, required no event",
                 cyc, step, load, err, position);
      end else begin
        e = exp_q.pop_front();
        if ({cyc, step, load, err, dir, position} !== {e.cyc, e.stp, e.ld, e.er, e.dr, e.pos})
          $display("FAIL event cyc=%0d step=%b load=%b err=%b dir=%b pos=%0h, required cyc=%0d step=%b load=%b err=%b dir=%b pos=%0h",
                   cyc, step, load, err, dir, position, e.cyc, e.stp, e.ld, e.er, e.dr, e.pos);
        else
          n_pass++;
      end
    end
  end

  task automatic push_ev(input int c, input logic s, input logic l, input logic r);
    ev_t e;
    e.cyc = c;
    e.stp = s;
    e.ld  = l;
    e.er  = r;
    e.dr  = exp_dir;
    e.pos = exp_pos;
    exp_q.push_back(e);
  endtask

  // One full detent of quadrature, each state held 10 cycles. The expected
  // step (if any) is queued when the final state is driven; sw_fall presses
  // the switch one cycle later so load lands on the same edge as the step.
  task automatic quad_cycle(input bit cw, input bit exp_stp, input bit sw_fall);
    logic [1:0] seq [4];
    int t;
    if (cw) seq = '{2'b01, 2'b00, 2'b10, 2'b11};
    else    seq = '{2'b10, 2'b00, 2'b01, 2'b11};
    for (int k = 0; k < 4; k++) begin
      {enc_a, enc_b} = seq[k];
      t = cyc;
      if (k == 3) begin
        exp_dir = cw;
        if (exp_stp) exp_pos = cw ? exp_pos + 8'd1 : exp_pos - 8'd1;
        if (exp_stp || sw_fall) push_ev(t + LAT_STEP, exp_stp, sw_fall, 1'b0);
      end
      repeat (10) begin
        @(negedge clk);
        if (k == 3 && sw_fall && cyc == t + 1) enc_sw = 1'b0;
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_total++;
    if (exp_q.size() !== 0)
      $display("FAIL %s_drained pending=%0d, required 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {enc_a, enc_b, enc_sw} = 3'b111;
    repeat (3) @(negedge clk);
    n_total += 5;
    if (position !== 8'h00) $display("FAIL reset_position got=%0h required=00", position); else n_pass++;
    if (load !== 1'b0) $display("FAIL reset_load got=%b required=0", load); else n_pass++;
    if (step !== 1'b0) $display("FAIL reset_step got=%b required=0", step); else n_pass++;
    if (dir !== 1'b0) $display("FAIL reset_dir got=%b required=0", dir); else n_pass++;
    if (err !== 1'b0) $display("FAIL reset_err got=%b required=0", err); else n_pass++;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (position !== 8'h00) $display("FAIL idle_position got=%0h required=00", position); else n_pass++;
    check_drained("idle");
  endtask

  task automatic test_cw();
    int t0;
    enc_a = 1'b0;
    t0 = cyc;
    repeat (LAT_FILT - 1) @(negedge clk);
    n_total++;
    if (dut.r_filt[0] !== 1'b1) $display("FAIL filt_a_early got=%b required=1 at +%0d", dut.r_filt[0], cyc - t0); else n_pass++;
    @(negedge clk);
    n_total++;
    if (dut.r_filt[0] !== 1'b0) $display("FAIL filt_a_latency got=%b required=0 at +%0d", dut.r_filt[0], cyc - t0); else n_pass++;
    repeat (10 - LAT_FILT) @(negedge clk);
    // Remaining three states of the CW detent.
    {enc_a, enc_b} = 2'b00;
    repeat (10) @(negedge clk);
    {enc_a, enc_b} = 2'b10;
    repeat (10) @(negedge clk);
    {enc_a, enc_b} = 2'b11;
    exp_dir = 1'b1;
    exp_pos = 8'd1;
    push_ev(cyc + LAT_STEP, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_total += 2;
    if (position !== 8'd1) $display("FAIL cw_position got=%0h required=01", position); else n_pass++;
    if (dir !== 1'b1) $display("FAIL cw_dir got=%b required=1", dir); else n_pass++;
    check_drained("cw");
  endtask

  task automatic test_ccw();
    quad_cycle(1'b0, 1'b1, 1'b0);
    // Now at 0: the next CCW detent wraps or saturates.
`ifdef EC11_SATURATE_EN
    quad_cycle(1'b0, 1'b0, 1'b0);
`else
    quad_cycle(1'b0, 1'b1, 1'b0);
`endif
    n_total += 2;
    if (position !== exp_pos) $display("FAIL ccw_position got=%0h required=%0h", position, exp_pos); else n_pass++;
    if (dir !== 1'b0) $display("FAIL ccw_dir got=%b required=0", dir); else n_pass++;
    check_drained("ccw");
  endtask

  task automatic test_glitch();
    int   changes;
    logic prev;
    changes = 0;
    prev = dut.r_filt[0];
    enc_a = 1'b0;
    @(negedge clk);
    enc_a = 1'b1;
    @(negedge clk);
    enc_a = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dut.r_filt[0] !== prev) begin
        changes++;
        prev = dut.r_filt[0];
      end
    end
    n_total++;
    if (changes !== 1) $display("FAIL glitch_filt_changes got=%0d required=1", changes); else n_pass++;
    enc_a = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (position !== exp_pos) $display("FAIL glitch_position got=%0h required=%0h", position, exp_pos); else n_pass++;
    check_drained("glitch");
  endtask

  task automatic test_err();
    {enc_a, enc_b} = 2'b00;
    push_ev(cyc + LAT_STEP, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    {enc_a, enc_b} = 2'b11;
    push_ev(cyc + LAT_STEP, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (position !== exp_pos) $display("FAIL err_position got=%0h required=%0h", position, exp_pos); else n_pass++;
    // A clean detent right after shows the accumulator was left at zero.
    quad_cycle(1'b1, 1'b1, 1'b0);
    n_total++;
    if (position !== exp_pos) $display("FAIL err_after_cw got=%0h required=%0h", position, exp_pos); else n_pass++;
    check_drained("err");
  endtask

  task automatic test_switch();
    enc_sw = 1'b0;
    push_ev(cyc + LAT_FILT, 1'b0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    enc_sw = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (position !== exp_pos) $display("FAIL sw_position got=%0h required=%0h", position, exp_pos); else n_pass++;
    check_drained("switch");
  endtask

  task automatic test_back_to_back();
    quad_cycle(1'b1, 1'b1, 1'b1);
    enc_sw = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (position !== exp_pos) $display("FAIL b2b_position got=%0h required=%0h", position, exp_pos); else n_pass++;
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    {enc_a, enc_b} = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_pos = '0;
    exp_dir = 1'b0;
    // Filtered levels restart at 1, so the resting 00 debounces as an error.
    push_ev(cyc + LAT_STEP, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    {enc_a, enc_b} = 2'b11;
    push_ev(cyc + LAT_STEP, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (position !== 8'h00) $display("FAIL rstmid_position got=%0h required=00", position); else n_pass++;
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_glitch();
    test_err();
    test_switch();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
